// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake between the pipeline and the iterative RV32M multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            StartE;
  logic [2:0]      Func3E;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            StallMD;
  logic            DoneE;
  logic [XLEN-1:0] ResultE;

  modport master (output StartE, Func3E, SrcAE, SrcBE, FlushE,
                  input  StallMD, DoneE, ResultE);
  modport slave  (input  StartE, Func3E, SrcAE, SrcBE, FlushE,
                  output StallMD, DoneE, ResultE);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add / restoring divide) with pipeline stall request.
// Defining MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave md
);
  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        func_q, func_d;
  logic              neg_q, neg_d;
  logic              negr_q, negr_d;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg2_if(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic            is_div, sign_a, sign_b, a_neg, b_neg;
  logic            div_zero, div_ovf, special, fast_hit;
  logic [XLEN-1:0] mag_a, mag_b, special_res, fast_res;

  // Issue-cycle decode: operand signedness, magnitudes and the divide corner cases.
  always_comb begin
    is_div      = md.Func3E[2];
    sign_a      = is_div ? ~md.Func3E[0] : (md.Func3E[1] ^ md.Func3E[0]);
    sign_b      = is_div ? ~md.Func3E[0] : (md.Func3E == 3'b001);
    a_neg       = sign_a & md.SrcAE[XLEN-1];
    b_neg       = sign_b & md.SrcBE[XLEN-1];
    mag_a       = neg_if(md.SrcAE, a_neg);
    mag_b       = neg_if(md.SrcBE, b_neg);
    div_zero    = is_div & (md.SrcBE == '0);
    div_ovf     = is_div & ~md.Func3E[0] & (md.SrcAE == MOST_NEG) & (md.SrcBE == '1);
    special     = div_zero | div_ovf;
    special_res = div_zero ? (md.Func3E[1] ? md.SrcAE : '1)
                           : (md.Func3E[1] ? '0 : md.SrcAE);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN-1:0] fast_p;

  always_comb begin
    fast_a   = {a_neg, md.SrcAE};
    fast_b   = {b_neg, md.SrcBE};
    fast_p   = $signed({{(XLEN-1){fast_a[XLEN]}}, fast_a}) *
               $signed({{(XLEN-1){fast_b[XLEN]}}, fast_b});
    fast_hit = ~is_div;
    fast_res = (md.Func3E[1:0] == 2'b00) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
  end
`else
  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
  end
`endif

  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] mul_step, div_step, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step = {mul_sum, acc_q[XLEN-1:1]};
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opb_q};
    div_step = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    prod_fix = neg2_if(acc_q, neg_q);
    quot_fix = neg_if(acc_q[XLEN-1:0], neg_q);
    rem_fix  = neg_if(acc_q[2*XLEN-1:XLEN], negr_q);
    if (func_q[2])
      fix_res = func_q[1] ? rem_fix : quot_fix;
    else
      fix_res = (func_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    if (md.FlushE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (md.StartE) state_d = (special || fast_hit) ? DONE : CALC;
        CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
        FIX:     state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d    = acc_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    func_d   = func_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (md.StartE && !md.FlushE) begin
          func_d = md.Func3E;
          cnt_d  = '0;
          neg_d  = a_neg ^ b_neg;
          negr_d = a_neg;
          opb_d  = is_div ? mag_b : mag_a;
          acc_d  = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
          if (special)       result_d = special_res;
          else if (fast_hit) result_d = fast_res;
        end
      end
      CALC: begin
        acc_d = func_q[2] ? div_step : mul_step;
        cnt_d = cnt_q + CW'(1);
      end
      FIX:     if (!md.FlushE) result_d = fix_res;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      func_q   <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      func_q   <= func_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  // A flush releases the stall in the same cycle so the pipeline can refill immediately.
  assign md.StallMD = ~md.FlushE & (((state_q == IDLE) & md.StartE) |
                                    (state_q == CALC) | (state_q == FIX));
  assign md.DoneE   = (state_q == DONE);
  assign md.ResultE = result_q;

endmodule
